// File: rtl/imu_spi_sequencer.sv
// imu_spi_sequencer: power-up wait, IMU register configuration, then interrupt-driven pitch-rate/AZ reads over SPI
module imu_spi_sequencer #(
  parameter int INIT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);
  typedef enum logic [2:0] {INIT, CFG, CFG_WT, IDLE, RD, RD_WT, PUB} state_t;
  state_t            state_q, state_d;
  logic [INIT_W-1:0] timer_q, timer_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][7:0]   byte_q, byte_d;
  logic [2:0]        int_q;
  logic              done_ff_q;
  logic              wrt_q, wrt_d, vld_q, vld_d;
  logic [15:0]       wt_data_q, wt_data_d, ptch_rt_q, ptch_rt_d, az_q, az_d;
  logic [15:0]       cfg_word, rd_word;
  logic              int_rise, done_rise;
  assign int_rise  = int_q[1] & ~int_q[2];
  assign done_rise = done & ~done_ff_q;
  assign cfg_word  = idx_q == 2'd0 ? 16'h0D02 : idx_q == 2'd1 ? 16'h1053 :
                     idx_q == 2'd2 ? 16'h1150 : 16'h1460;
  assign rd_word   = {idx_q == 2'd0 ? 8'hA2 : idx_q == 2'd1 ? 8'hA3 :
                      idx_q == 2'd2 ? 8'hAC : 8'hAD, 8'h00};
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    wrt_d     = 1'b0;
    vld_d     = 1'b0;
    wt_data_d = wt_data_q;
    ptch_rt_d = ptch_rt_q;
    az_d      = az_q;
    case (state_q)
      INIT: begin
        timer_d = timer_q + 1'b1;
        if (&timer_q) begin
          state_d = CFG;
          idx_d   = 2'd0;
        end
      end
      CFG: begin
        wrt_d     = 1'b1;
        wt_data_d = cfg_word;
        state_d   = CFG_WT;
      end
      CFG_WT: if (done_rise) begin
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? IDLE : CFG;
      end
      IDLE: if (int_rise) begin
        state_d = RD;
        idx_d   = 2'd0;
      end
      RD: begin
        wrt_d     = 1'b1;
        wt_data_d = rd_word;
        state_d   = RD_WT;
      end
      RD_WT: if (done_rise) begin
        byte_d[idx_q] = rd_data[7:0];
        idx_d         = idx_q + 2'd1;
        state_d       = idx_q == 2'd3 ? PUB : RD;
        // Publish as PUB is entered so vld is high exactly while in PUB; AZH comes straight from the bus
        if (idx_q == 2'd3) begin
          vld_d     = 1'b1;
          ptch_rt_d = {byte_q[1], byte_q[0]};
          az_d      = {rd_data[7:0], byte_q[2]};
        end
      end
      PUB:     state_d = IDLE;
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      timer_q   <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      int_q     <= '0;
      done_ff_q <= 1'b0;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;
      wt_data_q <= '0;
      ptch_rt_q <= '0;
      az_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      int_q     <= {int_q[1:0], INT};
      done_ff_q <= done;
      wrt_q     <= wrt_d;
      vld_q     <= vld_d;
      wt_data_q <= wt_data_d;
      ptch_rt_q <= ptch_rt_d;
      az_q      <= az_d;
    end
  end
  assign wrt     = wrt_q;
  assign vld     = vld_q;
  assign wt_data = wt_data_q;
  assign ptch_rt = ptch_rt_q;
  assign AZ      = az_q;
endmodule

// File: tb/tb_imu_spi_sequencer.sv
// tb_imu_spi_sequencer: transceiver model plus scoreboard of expected command words and published samples
module tb_imu_spi_sequencer;
  logic        clk = 1'b0;
  logic        rst, INT, done;
  logic [15:0] rd_data;
  logic        wrt, vld;
  logic [15:0] wt_data, ptch_rt, AZ;
  int          n_cmp = 0, n_err = 0;
  int          lat = 20, cyc = 0, wrt_seen = 0;
  bit          first_pend = 1'b1;
  logic [15:0] exp_wt[$];
  logic [31:0] exp_out[$];
  logic [7:0]  resp[4];
  logic [15:0] last_p = 16'h0, last_a = 16'h0;
  imu_spi_sequencer #(.INIT_W(4)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .wt_data(wt_data), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Transceiver: clears done after accepting wrt, raises it lat cycles later and holds it until the next wrt
  initial begin
    logic [15:0] cmd;
    bit busy;
    int cnt;
    done = 1'b0; rd_data = 16'h0; busy = 1'b0; cnt = 0; cmd = 16'h0;
    forever begin
      @(negedge clk);
      if (wrt) begin
        cmd = wt_data; busy = 1'b1; cnt = 0; done = 1'b0;
      end else if (busy) begin
        cnt++;
        if (cnt >= lat) begin
          busy = 1'b0;
          done = 1'b1;
          rd_data = cmd[15:8] == 8'hA2 ? {8'hE1, resp[0]} : cmd[15:8] == 8'hA3 ? {8'hE2, resp[1]} :
                    cmd[15:8] == 8'hAC ? {8'hE3, resp[2]} : cmd[15:8] == 8'hAD ? {8'hE4, resp[3]} : 16'hBEEF;
        end
      end
    end
  end
  initial begin
    logic [15:0] e;
    logic [31:0] o;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
        first_pend = 1'b1;
      end else begin
        cyc++;
        if (wrt) begin
          wrt_seen++;
          if (first_pend) begin
            first_pend = 1'b0;
            n_cmp++;
            if (cyc < 15) begin
              n_err++;
              $display("FAIL init_wait: first wrt at cycle %0d required >= 15", cyc);
            end
          end
          if (exp_wt.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wt_data: unexpected wrt with %h", wt_data);
          end else begin
            e = exp_wt.pop_front();
            chk("wt_data", {16'h0, wt_data}, {16'h0, e});
          end
        end
        if (vld) begin
          if (exp_out.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL vld: unexpected vld ptch_rt=%h AZ=%h", ptch_rt, AZ);
          end else begin
            o = exp_out.pop_front();
            chk("ptch_rt/AZ", {ptch_rt, AZ}, o);
          end
        end
      end
    end
  end
  task automatic drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_wt.size() == 0 && exp_out.size() == 0) break;
    end
    if (i == 3000) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: %0d words and %0d samples still expected", exp_wt.size(), exp_out.size());
      exp_wt.delete();
      exp_out.delete();
    end
    repeat (40) @(negedge clk);
    chk("hold", {ptch_rt, AZ}, {last_p, last_a});
  endtask
  task automatic push_cfg();
    exp_wt.push_back(16'h0D02); exp_wt.push_back(16'h1053);
    exp_wt.push_back(16'h1150); exp_wt.push_back(16'h1460);
  endtask
  task automatic push_seq(input logic [7:0] b0, b1, b2, b3);
    resp[0] = b0; resp[1] = b1; resp[2] = b2; resp[3] = b3;
    exp_wt.push_back(16'hA200); exp_wt.push_back(16'hA300);
    exp_wt.push_back(16'hAC00); exp_wt.push_back(16'hAD00);
    last_p = {b1, b0};
    last_a = {b3, b2};
    exp_out.push_back({last_p, last_a});
  endtask
  task automatic pulse_int(input int hi);
    INT = 1'b1;
    repeat (hi) @(negedge clk);
    INT = 1'b0;
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_wrt"}, {31'h0, wrt}, 32'h0);
    chk({name, "_wt_data"}, {16'h0, wt_data}, 32'h0);
    chk({name, "_out"}, {ptch_rt, AZ}, 32'h0);
    chk({name, "_vld"}, {31'h0, vld}, 32'h0);
  endtask
  initial begin
    int i;
    rst = 1'b1; INT = 1'b0;
    resp[0] = 8'h0; resp[1] = 8'h0; resp[2] = 8'h0; resp[3] = 8'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    push_cfg();
    rst = 1'b0;
    drain();
    push_seq(8'h34, 8'h12, 8'h78, 8'hF6);
    pulse_int(3);
    drain();
    lat = 1;
    push_seq(8'h01, 8'h80, 8'hFF, 8'h7F);
    pulse_int(2);
    drain();
    lat = 20;
    push_seq(8'h55, 8'h66, 8'h77, 8'h88);
    pulse_int(2);
    repeat (15) @(negedge clk);
    pulse_int(2);
    drain();
    push_seq(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    pulse_int(2);
    drain();
    push_seq(8'h0F, 8'hF0, 8'h11, 8'h22);
    INT = 1'b1;
    repeat (500) @(negedge clk);
    INT = 1'b0;
    drain();
    exp_wt.push_back(16'h0D02); exp_wt.push_back(16'h1053); exp_wt.push_back(16'h1150);
    wrt_seen = 0;
    rst = 1'b1;
    #1;
    chk_zero("rst_idle");
    @(negedge clk);
    rst = 1'b0;
    for (i = 0; i < 1000 && wrt_seen < 3; i++) @(negedge clk);
    if (wrt_seen < 3) begin
      n_cmp++; n_err++;
      $display("FAIL cfg3_wait: saw %0d wrt required 3", wrt_seen);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    last_p = 16'h0; last_a = 16'h0;
    push_cfg();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imu_spi_sequencer.md
Name: imu_spi_sequencer

Overview:
- Command sequencer directly upstream of the SPI main transceiver; drives its wrt/wt_data and consumes its done/rd_data.
- After reset, waits for IMU power-up, then writes four IMU configuration registers.
- Thereafter reads pitch rate and Z acceleration (low and high bytes) on every rising edge of the IMU data-ready interrupt.
- Presents 16-bit ptch_rt and AZ with a one-cycle vld strobe to the balance control datapath.

Parameters:
- INIT_W, 16, width of the power-up wait counter; the wait ends when the counter is all ones (2^INIT_W - 1 cycles); benches use 4.

Ports:
- clk  in  1  system clock; all flops posedge.
- rst  in  1  asynchronous active-high reset.
- INT  in  1  IMU data-ready interrupt; asynchronous to clk.
- done  in  1  transceiver transaction-complete level; cleared by the transceiver the cycle after it accepts wrt.
- rd_data  in  16  transceiver read data; IMU byte in [7:0].
- wrt  out  1  one-cycle transaction start pulse.
- wt_data  out  16  transaction word: {cmd/addr byte, data byte}.
- ptch_rt  out  16  signed pitch rate {high byte, low byte}.
- AZ  out  16  signed Z acceleration {high byte, low byte}.
- vld  out  1  one-cycle pulse; ptch_rt and AZ were updated this cycle.

Behaviour:
- Reset values (async on rst): wrt=0, wt_data=0, ptch_rt=0, AZ=0, vld=0, state=INIT, timer=0, captured bytes=0, synchronizer flops=0, done_ff=0.
- Reset mid-transaction: aborts immediately and returns to INIT, re-running the power-up wait and full configuration. Transceiver state is not tracked.
- INT synchronization: two flops, then a third flop for edge detection. int_rise = sync2 & ~sync3.
- done handling: done_rise = done & ~done_ff. Only done_rise advances the sequencer, so a stale done level from the previous transaction is never taken as completion.
- All outputs are registered. wrt and wt_data change in the same cycle. wt_data holds its value until the next wrt.
- States and transitions:
  - INIT: timer increments each cycle. When the timer is all ones, go to CFG with idx=0.
  - CFG: pulse wrt with the idx word, then go to CFG_WT.
    - Config words by idx: 0:0x0D02 (interrupt enable), 1:0x1053 (accel ODR/range), 2:0x1150 (gyro ODR/range), 3:0x1460 (rounding).
  - CFG_WT: on done_rise, increment idx and return to CFG, or go to IDLE after idx 3.
  - IDLE: on int_rise, go to RD with idx=0.
  - RD: pulse wrt with the idx read command, then go to RD_WT.
    - Read commands by idx: 0:0xA2xx (pitchL), 1:0xA3xx (pitchH), 2:0xACxx (AZL), 3:0xADxx (AZH). The low byte is 0x00.
  - RD_WT: on done_rise, capture rd_data[7:0] into byte idx. Increment idx and return to RD, or go to PUB after idx 3.
  - PUB: ptch_rt <= {pitchH, pitchL}, AZ <= {AZH, AZL}, vld=1 for exactly this cycle. Go to IDLE.
- Write-phase rd_data is ignored; the captured byte registers are untouched during CFG.
- Interrupt boundaries:
  - int_rise outside IDLE is dropped, not queued.
  - INT held high produces no further sequence until it falls and rises again.
- Simultaneous int_rise and the final config done_rise: the interrupt is dropped, because the FSM is not yet in IDLE.
- Outputs update only in PUB. ptch_rt and AZ hold their values between vld pulses.
- Bus-level latency: int_rise to first wrt is 2 cycles; last done_rise to vld is 1 cycle.
- Total cycles per read sequence = 4 transactions + 4×2 FSM cycles + synchronizer latency.

Test Plan:
- Power-up (INIT_W=4, transceiver model done 20 cycles after wrt) -> no wrt before cycle 15. Exactly four wrt pulses with wt_data 0x0D02, 0x1053, 0x1150, 0x1460 in order. Then IDLE with no further wrt.
- Single INT pulse, model returns 0x34, 0x12, 0x78, 0xF6 -> wt_data 0xA200, 0xA300, 0xAC00, 0xAD00. One vld pulse with ptch_rt=0x1234, AZ=0xF678.
- Stale done: model holds done high between transactions -> exactly one byte captured per transaction, and sequence order is unchanged.
- INT rising again during the RD phase of a sequence -> exactly one vld. A later clean INT edge gives a second vld with new values.
- INT held high for 500 cycles -> exactly one read sequence and one vld.
- rst asserted during the third config transaction -> all outputs 0 immediately. After release, the full wait and the four-word configuration repeat from 0x0D02.
